// File: rtl/ps2_pkg.sv
// Shared types and width helpers for the PS/2 message framer.
package ps2_pkg;

  typedef enum logic [1:0] {
    SEEK    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_e;

  // Byte index must be able to count up to and including MSG_BYTES.
  function automatic int unsigned idx_width(input int unsigned msg_bytes);
    return $clog2(msg_bytes + 1);
  endfunction

endpackage

// File: rtl/ps2_idle_timer.sv
// Idle-cycle counter: counts enabled cycles and flags the cycle on which the
// count would reach TIMEOUT_CYC; restarts from zero on clear or expiry.
module ps2_idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire = enable && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || expire) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_msg_framer.sv
// Frames a valid-qualified byte stream into MSG_BYTES-byte messages, using a
// sync bit in the first byte; optional inter-byte timeout and discard counter.
module ps2_msg_framer
  import ps2_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned MSG_BYTES   = 3,
  parameter int unsigned SYNC_BIT    = 3,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        done,
  output logic [MSG_BYTES*DATA_W-1:0] msg_out,
  output logic                        timeout_err,
  output logic [CNT_W-1:0]            discard_cnt
);

  // Handshake: in_valid qualifies in_data for exactly one cycle; there is no
  // ready, so every valid byte is consumed in the cycle it is presented.

  localparam int unsigned MSG_W = MSG_BYTES * DATA_W;
  localparam int unsigned IDX_W = idx_width(MSG_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [MSG_W-1:0]   shift_q, shift_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic               done_q, done_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0]   discard_q, discard_d;
  logic [MSG_W-1:0]   shifted;
  logic               timer_expire;

  assign shifted = {shift_q[MSG_W-DATA_W-1:0], in_data};

  generate
    if (TIMEOUT_CYC > 0) begin : g_timer
      ps2_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
      ) u_idle_timer (
        .clk   (clk),
        .reset (reset),
        .clear ((state_q != COLLECT) || in_valid),
        .enable((state_q == COLLECT) && !in_valid),
        .expire(timer_expire)
      );
    end else begin : g_no_timer
      assign timer_expire = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    msg_d         = msg_q;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    discard_d     = discard_q;
    case (state_q)
      COLLECT: begin
        if (in_valid) begin
          shift_d = shifted;
          if (idx_q == LAST_IDX) begin
            msg_d   = shifted;
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else if (timer_expire) begin
          shift_d       = '0;
          idx_d         = '0;
          timeout_err_d = 1'b1;
          state_d       = SEEK;
        end
      end
      // DONE behaves like SEEK so a new message can start with no lost cycle.
      default: begin
        state_d = SEEK;
        if (in_valid) begin
          if (in_data[SYNC_BIT]) begin
            shift_d = MSG_W'(in_data);
            idx_d   = IDX_W'(1);
            state_d = COLLECT;
          end else if (discard_q != '1) begin
            discard_d = discard_q + CNT_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SEEK;
      idx_q         <= '0;
      shift_q       <= '0;
      msg_q         <= '0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      msg_q         <= msg_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      discard_q     <= discard_d;
    end
  end

  assign done        = done_q;
  assign msg_out     = msg_q;
  assign timeout_err = timeout_err_q;
  assign discard_cnt = discard_q;

endmodule

// File: doc/ps2_msg_framer.md
Name: ps2_msg_framer

Overview:
- Parametrised successor to the fixed 3-byte message FSM.
- Finds message boundaries in a byte stream with a valid qualifier, using a sync bit in the first byte of each message.
- Assembles MSG_BYTES bytes into one word and pulses done for one cycle per complete message.
- Adds an inter-byte timeout and a saturating discard counter.
- Sits between the byte-level PS/2 deserialiser and the host-side message decoder.

Parameters:
- DATA_W, 8: width of each input byte.
- MSG_BYTES, 3: bytes per message; legal range 2..8.
- SYNC_BIT, 3: bit index in in_data that must be 1 for a byte to start a message; must be < DATA_W.
- TIMEOUT_CYC, 0: maximum idle cycles between bytes inside a message; 0 disables the timeout.
- CNT_W, 16: width of discard_cnt.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, synchronous, active-high; clock clk.
- in_valid, input, 1: in_data holds a byte this cycle; there is no backpressure.
- in_data, input, DATA_W: incoming byte.
- done, output, 1: one-cycle pulse when msg_out has just been updated with a complete message.
- msg_out, output, MSG_BYTES*DATA_W: last complete message; first byte in the MS byte, last byte in the LS byte.
- timeout_err, output, 1: one-cycle pulse when a partial message is dropped on timeout.
- discard_cnt, output, CNT_W: saturating count of bytes discarded while seeking sync.

Behaviour:
- Reset values: done=0, msg_out=0, timeout_err=0, discard_cnt=0, state=SEEK, byte index=0, idle counter=0, shift register=0.
- Reset mid-message drops the partial message and raises no error pulse.
- Only cycles with in_valid=1 advance the FSM.
- States are SEEK, COLLECT and DONE.
- SEEK:
  - in_valid with in_data[SYNC_BIT]=1: capture the byte, set index=1, go to COLLECT.
  - in_valid with in_data[SYNC_BIT]=0: discard_cnt += 1, saturating at all-ones; stay in SEEK.
- COLLECT:
  - in_valid: shift the byte in and increment index. The sync bit is NOT checked on non-first bytes.
  - When the MSG_BYTES-th byte is accepted, load msg_out with all assembled bytes on the same clock edge and go to DONE.
- DONE:
  - done=1 for exactly this cycle; msg_out is valid from this cycle until the next done.
  - A byte arriving in this cycle is handled exactly as in SEEK, so back-to-back messages lose no cycle.
- Latency: done rises on the cycle after the clock edge that captures the last byte.
- done is a registered, state-derived output; it has no combinational path from inputs.
- Timeout (TIMEOUT_CYC>0):
  - In COLLECT only, the idle counter increments on every cycle with in_valid=0 and clears on in_valid=1.
  - When the counter reaches TIMEOUT_CYC while in_valid=0, drop the partial message, pulse timeout_err on the next cycle, clear index, and go to SEEK.
  - If in_valid=1 arrives in the same cycle the count would expire, the byte is accepted and no timeout occurs.
  - With TIMEOUT_CYC=0 the counter logic is constant-folded away and timeout_err stays 0.
- msg_out is never modified by a partial or dropped message.
- Width rules:
  - Byte index width is $clog2(MSG_BYTES+1).
  - Idle counter width is $clog2(TIMEOUT_CYC+1), with a minimum of 1.
  - discard_cnt never wraps.

Decomposition:
- Shared package ps2_pkg holds:
  - the state enum typedef (SEEK, COLLECT, DONE; 2-bit encoding);
  - a localparam function that computes the index width.
- One natural sub-module, ps2_idle_timer: a parametrised idle counter with inputs clear/enable and a one-cycle expire output.
  - It is instantiated only when TIMEOUT_CYC>0, via a generate block.

Test Plan:
- Defaults; bytes 0x08,0x11,0x22 with in_valid=1 on consecutive cycles -> done pulses once on the cycle after 0x22; msg_out=0x081122.
- Defaults; bytes 0x00,0x01,0x08,0xAA,0xBB -> discard_cnt=2; one done with msg_out=0x08AABB.
- Back-to-back messages 0x08,0x01,0x02,0x0C,0x03,0x04 with no gaps -> done on two cycles exactly 3 cycles apart; msg_out=0x080102 then 0x0C0304.
- TIMEOUT_CYC=4; send 0x08,0x55, hold in_valid=0 for 4 cycles -> timeout_err pulses once; then send 0x08,0x01,0x02 -> msg_out=0x080102.
  - Repeat with a 3-cycle gap -> no timeout; message completes normally.
- MSG_BYTES=4, DATA_W=8; bytes 0x08,0x11,0x22,0x33 with in_valid toggling 1/0 -> done once after 0x33; msg_out=0x08112233.
- Reset asserted after the 2nd byte of a message -> all outputs 0; the next 3 sync-aligned bytes produce a correct message.
- CNT_W=2 with 5 non-sync bytes -> discard_cnt saturates at 3.
